mmm_core: RTL and testbench
===========================

MMM_CORE -- requirements
Module: mmm_core

Interface
REQ-001 Parameter WIDTH SHALL default to 8: operand/modulus bit width, legal range 4..32.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rstb  input  1  reset; synchronous, active-low.
REQ-004 en  input  1  clock enable; when low, all registers including outputs SHALL hold.
REQ-005 start  input  1  request one multiplication; sampled only in IDLE with en=1.
REQ-006 a  input  WIDTH  multiplier operand; a < m required.
REQ-007 b  input  WIDTH  multiplicand operand; b < m required.
REQ-008 m  input  WIDTH  modulus; odd required.
REQ-009 result  output  WIDTH  registered a*b*2^-WIDTH mod m.
REQ-010 busy  output  1  high from start acceptance until completion.
REQ-011 done  output  1  registered completion pulse.

Function
REQ-012 FSM states SHALL be IDLE, RUN and SUB.
REQ-013 IDLE with en=1 and start=1 SHALL capture a, b and m, clear accumulator and iteration counter, set busy=1, and go to RUN.
REQ-014 Each enabled RUN cycle i (0..WIDTH-1) SHALL compute t = acc + a[i]*b; q = t[0]; acc <= (t + q*m) >> 1.
REQ-015 Intermediate sum SHALL be WIDTH+2 bits and acc WIDTH+1 bits; no truncation.
REQ-016 After WIDTH RUN iterations the FSM SHALL enter SUB.
REQ-017 SUB SHALL load result with (acc >= m) ? acc - m : acc, set done=1, set busy=0, and return to IDLE.
REQ-018 Latency SHALL be exactly WIDTH+1 enabled cycles from start acceptance to done high.
REQ-019 done SHALL stay high for exactly one enabled cycle; while en=0 it SHALL hold its value.
REQ-020 result SHALL hold its value until the next SUB.
REQ-021 start while busy=1 SHALL be ignored, with no effect on operands or timing.
REQ-022 start in the cycle done=1 SHALL be accepted, giving back-to-back operation with no dead cycle.
REQ-023 en=0 mid-operation SHALL freeze the FSM, counter and acc; computation resumes unchanged when en=1.
REQ-024 An even m SHALL still complete in WIDTH+1 cycles; the result value is don't-care.

Reset
REQ-025 rstb=0 at a rising edge SHALL set state=IDLE, busy=0, done=0, result=0, acc=0 and counter=0, regardless of en.
REQ-026 Reset mid-operation SHALL abort the operation with no done pulse.

Structure
REQ-027 Package rsa_pkg SHALL hold the WIDTH default, the FSM state encoding and the constant MMM_LATENCY = WIDTH+1.
REQ-028 The combinational iteration step (t, q, shifted acc) SHALL be a sub-module mmm_step, instantiated once.

Verification
REQ-029 WIDTH=8, m=13, a=5, b=7, start -> done 9 cycles later, result=1, busy high for exactly 9 cycles.
REQ-030 WIDTH=8, m=255, a=254, b=254 -> result=1, with no overflow on the wide path.
REQ-031 m=13, a=0, b=12 -> result=0; then a=1, b=1 started back-to-back in the done cycle -> result=3 nine cycles later.
REQ-032 m=13, a=5, b=7 with en low for 3 cycles mid-RUN -> done after 9 enabled cycles (12 clocks), result=1.
REQ-033 start pulsed again during busy with different operands -> ignored; first result=1 and no second done.
REQ-034 rstb low in cycle 4 of RUN -> next cycle busy=0, done=0, result=0, and no done follows.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared constants and FSM encoding for the Montgomery modular multiplier.
package rsa_pkg;

    localparam int unsigned MMM_WIDTH   = 8;
    localparam int unsigned MMM_LATENCY = MMM_WIDTH + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StSub  = 2'd2
    } mmm_state_e;

endpackage

// File: rtl/mmm_step.sv
// One radix-2 Montgomery iteration: t = acc + a_i*b, then (t + t[0]*m) >> 1.
module mmm_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic             a_bit_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   acc_o
);

    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] u;
    logic             q;

    // acc < 2m keeps t < 3m and u < 4m, so WIDTH+2 bits never overflow.
    always_comb begin
        t     = {1'b0, acc_i} + (a_bit_i ? {2'b00, b_i} : '0);
        q     = t[0];
        u     = t + (q ? {2'b00, m_i} : '0);
        acc_o = u[WIDTH+1:1];
    end

endmodule

// File: rtl/mmm_core.sv
// Iterative Montgomery multiplier: result = a*b*2^-WIDTH mod m, WIDTH+1 cycles per operation.
module mmm_core
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = MMM_WIDTH
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    mmm_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   acc_step;
    logic [WIDTH:0]   acc_minus_m;

    // a_q is shifted right each iteration so bit 0 is always the current a[i].
    mmm_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i   (acc_q),
        .a_bit_i (a_q[0]),
        .b_i     (b_q),
        .m_i     (m_q),
        .acc_o   (acc_step)
    );

    assign acc_minus_m = acc_q - {1'b0, m_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    m_d     = m;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_step;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StSub;
                end
            end
            StSub: begin
                result_d = (acc_q >= {1'b0, m_q}) ? acc_minus_m[WIDTH-1:0] : acc_q[WIDTH-1:0];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (en) begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mmm_core.sv
// Directed self-checking bench for mmm_core at WIDTH=8.
module tb_mmm_core;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rstb;
    logic         en;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] m;
    logic [W-1:0] result;
    logic         busy;
    logic         done;

    int checks;
    int failures;

    mmm_core #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rstb   (rstb),
        .en     (en),
        .start  (start),
        .a      (a),
        .b      (b),
        .m      (m),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue start for one edge (the accepting edge), then release it.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] mv);
        a     = av;
        b     = bv;
        m     = mv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Clocks until done is seen (-1 on timeout); also counts cycles with busy high.
    task automatic wait_done(output int n, output int busy_cnt);
        n        = -1;
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rstb  = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        m     = 8'd13;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b result=%0d, want 0 0 0", busy, done, result);
        end
        rstb = 1'b1;
        en   = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n, bc;
        launch(8'd5, 8'd7, 8'd13);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_set: busy=%b, want 1", busy);
        end
        wait_done(n, bc);
        checks++;
        if (n != 9) begin
            failures++;
            $display("FAIL basic_latency: got %0d, want 9", n);
        end
        checks++;
        if (bc != 9) begin
            failures++;
            $display("FAIL basic_busy_len: got %0d, want 9", bc);
        end
        checks++;
        if (result !== 8'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: result=%0d busy=%b, want 1 0", result, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || result !== 8'd1) begin
            failures++;
            $display("FAIL basic_pulse: done=%b result=%0d, want 0 1", done, result);
        end
    endtask

    task automatic test_wide();
        int n, bc;
        launch(8'd254, 8'd254, 8'd255);
        wait_done(n, bc);
        checks++;
        if (n != 9 || result !== 8'd1) begin
            failures++;
            $display("FAIL wide: latency=%0d result=%0d, want 9 1", n, result);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n, bc;
        launch(8'd0, 8'd12, 8'd13);
        wait_done(n, bc);
        checks++;
        if (n != 9 || result !== 8'd0) begin
            failures++;
            $display("FAIL b2b_first: latency=%0d result=%0d, want 9 0", n, result);
        end
        launch(8'd1, 8'd1, 8'd13);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy, done);
        end
        wait_done(n, bc);
        checks++;
        if (n != 9 || result !== 8'd3) begin
            failures++;
            $display("FAIL b2b_second: latency=%0d result=%0d, want 9 3", n, result);
        end
        tick();
    endtask

    task automatic test_enable();
        int  n;
        logic bad;
        n   = -1;
        bad = 1'b0;
        launch(8'd5, 8'd7, 8'd13);
        for (int i = 1; i <= 40; i++) begin
            en = !(i >= 4 && i <= 6);
            tick();
            if (!en && (busy !== 1'b1 || done !== 1'b0)) bad = 1'b1;
            if (done) begin
                n = i;
                break;
            end
        end
        en = 1'b1;
        checks++;
        if (n != 12 || result !== 8'd1) begin
            failures++;
            $display("FAIL enable_latency: clocks=%0d result=%0d, want 12 1", n, result);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL enable_freeze: busy/done changed while en=0");
        end
        en = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL enable_done_hold: done=%b, want 1", done);
        end
        en = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL enable_done_clear: done=%b, want 0", done);
        end
    endtask

    task automatic test_ignore_start();
        int n, bc, extra;
        launch(8'd5, 8'd7, 8'd13);
        tick();
        tick();
        launch(8'd1, 8'd1, 8'd11);
        wait_done(n, bc);
        // 3 edges already elapsed since acceptance
        checks++;
        if (n != 6 || result !== 8'd1) begin
            failures++;
            $display("FAIL ignore_first: remaining=%0d result=%0d, want 6 1", n, result);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) extra++;
        end
        checks++;
        if (extra != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_no_second: extra_done=%0d busy=%b, want 0 0", extra, busy);
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        launch(8'd5, 8'd7, 8'd13);
        tick();
        tick();
        tick();
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b result=%0d, want 0 0 0", busy, done, result);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", extra);
        end
    endtask

    task automatic test_even_modulus();
        int n, bc;
        launch(8'd5, 8'd7, 8'd12);
        wait_done(n, bc);
        checks++;
        if (n != 9) begin
            failures++;
            $display("FAIL even_latency: got %0d, want 9", n);
        end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_wide();
        test_back_to_back();
        test_enable();
        test_ignore_start();
        test_reset_mid();
        test_even_modulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
